core_acc_drain: RTL and testbench
=================================

// Module: core_acc_drain
// PURPOSE
//  - Consumer of the accumulator result stream (odata/odata_valid of the accumulation stage). No backpressure exists upstream.
//  - Requantizes each accumulated psum: arithmetic right shift by cfg_shift, then saturation to ODATA_BIT.
//  - Buffers results in a small FIFO and drains them to the next stage over a valid/ready handshake.
//  - Samples that arrive while the FIFO is full are dropped and flagged.
// PARAMETERS
//  IDATA_BIT   16  width of incoming signed accumulated psum
//  ODATA_BIT   8   width of outgoing signed requantized result
//  CDATA_BIT   8   width of config fields
//  FIFO_DEPTH  4   result FIFO entries; power of 2, >=2
// PORTS
//  clk            in   1          clock
//  rstn           in   1          async active-low reset
//  cfg_shift      in   CDATA_BIT  right-shift amount; quasi-static, change only while idle
//  cfg_clr_flag   in   1          1-cycle pulse clears drop_flag and sat_flag
//  idata          in   IDATA_BIT  signed psum from accumulator
//  idata_valid    in   1          idata qualifier; 1-cycle pulses, may be back-to-back
//  odata          out  ODATA_BIT  signed requantized result, FIFO head
//  odata_valid    out  1          FIFO non-empty
//  odata_ready    in   1          downstream accept; transfer when odata_valid & odata_ready
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  current occupancy
//  drop_flag      out  1          sticky: a result was discarded on full FIFO
//  sat_flag       out  1          sticky: a result was clipped by saturation
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, stage register invalid. Reset mid-operation discards all buffered data.
//  - Stage Q (1 cycle): on idata_valid, register q = sat(round(idata) >>> cfg_shift); q_valid <= idata_valid.
//  - Arithmetic is done in IDATA_BIT+1 bits so that the rounding add cannot overflow.
//      cfg_shift >= IDATA_BIT behaves as shift IDATA_BIT (result 0 or -1).
//  - Saturation clips to [-2^(ODATA_BIT-1), 2^(ODATA_BIT-1)-1].
//      sat_flag sets on the cycle q is registered with clipping.
//  - Push: q_valid pushes q into the FIFO at the end of that cycle.
//      Latency: idata_valid in cycle t -> odata_valid in t+2 (FIFO empty, ready ignored).
//  - FIFO is first-word-fall-through: odata = head entry, odata_valid = (level != 0).
//      odata is held stable while valid & !ready.
//  - Pop happens on odata_valid & odata_ready.
//  - Simultaneous push+pop: level unchanged. This is allowed when full, and the push is accepted.
//  - Push while full without pop: sample dropped, level stays FIFO_DEPTH, drop_flag <= 1.
//  - Pop while empty: impossible, because odata_valid=0.
//  - Pointers wrap modulo FIFO_DEPTH.
//  - Flags are sticky until cfg_clr_flag or reset. A set event in the same cycle as cfg_clr_flag wins (flag stays 1).
// CONFIGURATION
//  CORE_ACC_DRAIN_ROUND_EN
//    defined: round-half-up. Add 2^(cfg_shift-1) before the shift when cfg_shift>0.
//    undefined: truncation (floor, plain >>>).
//  Both variants keep identical latency and ports.
// STRUCTURE
//  - Shared package core_acc_pkg: default IDATA/ODATA/CDATA widths, FIFO_DEPTH default, sat_min/sat_max constant functions.
//  - Sub-module core_acc_drain_fifo: FWFT FIFO with push, pop, full, empty and level.
//  - Requant stage and flags live in the top.
// TESTING
//  1. Reset, then idle -> odata_valid=0, fifo_level=0, flags 0. Reset asserted with 3 entries -> all cleared immediately.
//  2. shift=4, idata=0x0123 with ready=1 -> odata=0x12 (0x12 also with ROUND_EN), valid 2 cycles after input.
//     idata=0x0128 -> 0x12 truncated, 0x13 with ROUND_EN.
//  3. shift=0, idata=0x0200 -> odata=0x7F, sat_flag=1. idata=0xFE00 -> odata=0x80.
//     cfg_clr_flag pulse -> sat_flag=0.
//  4. ready=0, 6 back-to-back inputs 1..6 -> fifo_level=4, drop_flag=1.
//     Then ready=1 -> outputs 1,2,3,4 in order, then valid=0.
//  5. FIFO full, then input and ready=1 in the same cycle -> level stays 4, no drop, new value is last out.
//  6. shift=20 with idata=-5 -> odata=-1 (0xFF). idata=+5 -> 0.

Source files
------------

// File: rtl/core_acc_pkg.sv
// Shared defaults and saturation helpers for the accumulator drain path.
package core_acc_pkg;

    localparam int IDATA_BIT_DEF  = 16;
    localparam int ODATA_BIT_DEF  = 8;
    localparam int CDATA_BIT_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // Signed range limits of a w-bit two's complement value.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/core_acc_drain_fifo.sv
// First-word-fall-through result FIFO: head entry is always visible on dout.
module core_acc_drain_fifo
    import core_acc_pkg::*;
#(
    parameter int DATA_W = ODATA_BIT_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [LVL_W-1:0]  level_next;
    logic              pop_ok;
    logic              wr_ok;

    assign full   = (level_reg == LVL_W'(DEPTH));
    assign empty  = (level_reg == '0);
    assign pop_ok = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push on full is still taken.
    assign wr_ok  = push & (~full | pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    mem_reg[gi] <= '0;
                end else if (wr_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    always_comb begin
        level_next = level_reg;
        case ({wr_ok, pop_ok})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_ok)  wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            level_reg <= level_next;
        end
    end

    assign dout  = empty ? '0 : mem_reg[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/core_acc_drain.sv
// Requantizes accumulator psums (shift + saturate) and drains them through a FWFT FIFO.
// Build option: define CORE_ACC_DRAIN_ROUND_EN for round-half-up instead of truncation.
module core_acc_drain
    import core_acc_pkg::*;
#(
    parameter int IDATA_BIT  = IDATA_BIT_DEF,
    parameter int ODATA_BIT  = ODATA_BIT_DEF,
    parameter int CDATA_BIT  = CDATA_BIT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [CDATA_BIT-1:0]          cfg_shift,
    input  logic                          cfg_clr_flag,
    input  logic [IDATA_BIT-1:0]          idata,
    input  logic                          idata_valid,
    output logic [ODATA_BIT-1:0]          odata,
    output logic                          odata_valid,
    input  logic                          odata_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drop_flag,
    output logic                          sat_flag
);

    localparam int EXT_W = IDATA_BIT + 1;
    localparam int SH_W  = $clog2(IDATA_BIT + 1);
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(sat_max(ODATA_BIT));
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(sat_min(ODATA_BIT));

    logic [SH_W-1:0]         sh;
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd_add;
    logic signed [EXT_W-1:0] summed;
    logic signed [EXT_W-1:0] shifted;
    logic [ODATA_BIT-1:0]    q_reg;
    logic [ODATA_BIT-1:0]    q_next;
    logic                    q_valid_reg;
    logic                    clip;
    logic                    sat_flag_reg;
    logic                    sat_flag_next;
    logic                    drop_flag_reg;
    logic                    drop_flag_next;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;

    // Shifts past the input width all collapse to a full-width shift (0 or -1).
    always_comb begin
        sh = cfg_shift[SH_W-1:0];
        if (int'(cfg_shift) >= IDATA_BIT) sh = SH_W'(IDATA_BIT);
    end

    always_comb begin
        ext     = {idata[IDATA_BIT-1], idata};
        rnd_add = '0;
`ifdef CORE_ACC_DRAIN_ROUND_EN
        if (sh != '0) rnd_add = {{(EXT_W-1){1'b0}}, 1'b1} << (sh - SH_W'(1));
`endif
        summed  = ext + rnd_add;
        shifted = summed >>> sh;
        clip    = 1'b0;
        q_next  = shifted[ODATA_BIT-1:0];
        if (shifted > SAT_HI) begin
            q_next = SAT_HI[ODATA_BIT-1:0];
            clip   = 1'b1;
        end else if (shifted < SAT_LO) begin
            q_next = SAT_LO[ODATA_BIT-1:0];
            clip   = 1'b1;
        end
    end

    assign pop = odata_valid & odata_ready;

    // A set event in the clear cycle keeps the flag high.
    always_comb begin
        sat_flag_next  = (idata_valid & clip) | (sat_flag_reg & ~cfg_clr_flag);
        drop_flag_next = (q_valid_reg & fifo_full & ~pop) | (drop_flag_reg & ~cfg_clr_flag);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_reg         <= '0;
            q_valid_reg   <= 1'b0;
            sat_flag_reg  <= 1'b0;
            drop_flag_reg <= 1'b0;
        end else begin
            if (idata_valid) q_reg <= q_next;
            q_valid_reg   <= idata_valid;
            sat_flag_reg  <= sat_flag_next;
            drop_flag_reg <= drop_flag_next;
        end
    end

    core_acc_drain_fifo #(
        .DATA_W (ODATA_BIT),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (q_valid_reg),
        .din   (q_reg),
        .pop   (pop),
        .dout  (odata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign odata_valid = ~fifo_empty;
    assign sat_flag    = sat_flag_reg;
    assign drop_flag   = drop_flag_reg;

endmodule

// File: tb/tb_core_acc_drain.sv
// Directed bench for core_acc_drain with a queue scoreboard and an independent output monitor.
module tb_core_acc_drain;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  cfg_shift;
    logic        cfg_clr_flag;
    logic [15:0] idata;
    logic        idata_valid;
    logic [7:0]  odata;
    logic        odata_valid;
    logic        odata_ready;
    logic [2:0]  fifo_level;
    logic        drop_flag;
    logic        sat_flag;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    core_acc_drain dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_shift    (cfg_shift),
        .cfg_clr_flag (cfg_clr_flag),
        .idata        (idata),
        .idata_valid  (idata_valid),
        .odata        (odata),
        .odata_valid  (odata_valid),
        .odata_ready  (odata_ready),
        .fifo_level   (fifo_level),
        .drop_flag    (drop_flag),
        .sat_flag     (sat_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every accepted transfer pops the scoreboard; a stalled head must match too.
    always @(negedge clk) begin
        if (rstn && odata_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got 0x%0h expected none", odata);
            end else if (odata_ready) begin
                check("xfer", {24'd0, odata}, {24'd0, sb.pop_front()});
            end else begin
                check("held_head", {24'd0, odata}, {24'd0, sb[0]});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] v, input logic [7:0] e, input bit keep);
        idata       = v;
        idata_valid = 1'b1;
        if (keep) sb.push_back(e);
        @(posedge clk);
        #1;
        idata_valid = 1'b0;
    endtask

    task automatic clr_flags();
        cfg_clr_flag = 1'b1;
        cycles(1);
        cfg_clr_flag = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        odata_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            cycles(1);
            n++;
        end
        cycles(1);
        check({name, "_left"}, sb.size(), 0);
        check({name, "_valid_after"}, {31'd0, odata_valid}, 0);
    endtask

    initial begin
        logic [7:0] exp128;
        logic [7:0] exp_neg5;
        rstn = 1'b0; cfg_shift = 8'd4; cfg_clr_flag = 1'b0;
        idata = '0; idata_valid = 1'b0; odata_ready = 1'b0;
        cycles(3);
        @(negedge clk) rstn = 1'b1;
        cycles(2);
        // 1: idle after reset
        check("rst_valid", {31'd0, odata_valid}, 0);
        check("rst_level", {29'd0, fifo_level}, 0);
        check("rst_drop", {31'd0, drop_flag}, 0);
        check("rst_sat", {31'd0, sat_flag}, 0);
        check("rst_odata", {24'd0, odata}, 0);

        // reset while three entries are buffered
        send(16'h0010, 8'h01, 1'b1);
        send(16'h0020, 8'h02, 1'b1);
        send(16'h0030, 8'h03, 1'b1);
        cycles(2);
        check("pre_rst_level", {29'd0, fifo_level}, 3);
        #2 rstn = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_level", {29'd0, fifo_level}, 0);
        check("mid_rst_valid", {31'd0, odata_valid}, 0);
        @(negedge clk) rstn = 1'b1;
        cycles(1);

        // 2: shift=4, latency and rounding
        cfg_shift = 8'd4;
        odata_ready = 1'b1;
        idata = 16'h0123; idata_valid = 1'b1; sb.push_back(8'h12);
        cycles(1);
        idata_valid = 1'b0;
        check("lat_t1_valid", {31'd0, odata_valid}, 0);
        cycles(1);
        check("lat_t2_valid", {31'd0, odata_valid}, 1);
`ifdef CORE_ACC_DRAIN_ROUND_EN
        exp128 = 8'h13;
`else
        exp128 = 8'h12;
`endif
        send(16'h0128, exp128, 1'b1);
        drain("t2");
        check("t2_sat", {31'd0, sat_flag}, 0);

        // 3: saturation and flag clear
        cfg_shift = 8'd0;
        send(16'h0200, 8'h7F, 1'b1);
        send(16'hFE00, 8'h80, 1'b1);
        drain("t3");
        check("t3_sat_set", {31'd0, sat_flag}, 1);
        clr_flags();
        check("t3_sat_clr", {31'd0, sat_flag}, 0);

        // 4: overflow with downstream stalled
        odata_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(16'(i), 8'(i), i <= 4);
        cycles(3);
        check("t4_level", {29'd0, fifo_level}, 4);
        check("t4_drop", {31'd0, drop_flag}, 1);
        drain("t4");
        clr_flags();
        check("t4_drop_clr", {31'd0, drop_flag}, 0);

        // 5: push and pop together while full
        odata_ready = 1'b0;
        for (int i = 10; i <= 13; i++) send(16'(i), 8'(i), 1'b1);
        cycles(2);
        check("t5_full", {29'd0, fifo_level}, 4);
        idata = 16'd14; idata_valid = 1'b1; sb.push_back(8'd14);
        cycles(1);
        idata_valid = 1'b0;
        odata_ready = 1'b1;
        cycles(1);
        odata_ready = 1'b0;
        check("t5_level", {29'd0, fifo_level}, 4);
        check("t5_drop", {31'd0, drop_flag}, 0);
        drain("t5");

        // 6: shift beyond input width
        cfg_shift = 8'd20;
`ifdef CORE_ACC_DRAIN_ROUND_EN
        exp_neg5 = 8'h00;
`else
        exp_neg5 = 8'hFF;
`endif
        send(16'hFFFB, exp_neg5, 1'b1);
        send(16'h0005, 8'h00, 1'b1);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
